word_mem_sequencer: RTL

- Shares one byte-wide memory port between the instruction-fetch requester and the data load/store requester.
- Serializes every 32-bit word access into four big-endian byte beats, matching the byte-addressed 8-bit memory arrays used by the processor.
- Sits between the processor core and a single unified 8-bit memory. The core stalls on each requester until that requester's ack.

---
 rtl/word_mem_sequencer_pkg.sv | 19 +
 rtl/byte_lane_assembler.sv | 36 +++
 rtl/word_mem_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/word_mem_sequencer_pkg.sv
// Shared definitions for the word/byte memory sequencer.
//   state_t    : sequencer FSM states
//   BEATS      : byte beats per 32-bit word
//   BYTE_W     : memory data width
//   REQ_IF/D   : requester identifiers (also the encoding of last_gnt)
package word_mem_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int   BEATS  = 4;
    localparam int   BYTE_W = 8;
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/byte_lane_assembler.sv
// Collects four memory read bytes into one big-endian 32-bit word.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   beat       : beat index 0..3; beat 0 lands in word[31:24]
//   din        : memory read byte
//   cap_en     : capture din into the lane selected by beat
//   clr        : zero the word at the start of a transaction
//   word       : assembled word register
module byte_lane_assembler
    import word_mem_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        beat,
    input  logic [BYTE_W-1:0] din,
    input  logic              cap_en,
    input  logic              clr,
    output logic [31:0]       word
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (clr) begin
            word <= '0;
        end else if (cap_en) begin
            case (beat)
                2'd0:    word[31:24] <= din;
                2'd1:    word[23:16] <= din;
                2'd2:    word[15:8]  <= din;
                default: word[7:0]   <= din;
            endcase
        end
    end

endmodule

// File: rtl/word_mem_sequencer.sv
// Shares one byte-wide memory port between instruction fetch and data
// load/store. Each 32-bit access becomes four big-endian byte beats.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   if_req/if_addr           : fetch word-read request (level) and byte address
//   if_rdata/if_ack          : fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata: data request (level), write enable, address, word
//   d_rdata/d_ack            : read word (0 for writes), one-cycle completion
//   m_addr/m_we/m_wdata      : memory byte address, write strobe, write byte
//   m_rdata                  : memory read byte, combinational from m_addr
//   busy                     : high whenever the sequencer is not idle
module word_mem_sequencer
    import word_mem_sequencer_pkg::*;
#(
    parameter int   ADDR_W    = 5,
    parameter logic FIRST_GNT = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [BYTE_W-1:0] m_wdata,
    input  logic [BYTE_W-1:0] m_rdata,
    output logic              busy
);

    state_t            state;
    logic [1:0]        beat;
    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              last_gnt;
    logic              mask_if;
    logic              mask_d;
    logic [31:0]       asm_word;

    logic              vld_if;
    logic              vld_d;
    logic              gnt_d;
    logic [ADDR_W-1:0] g_addr;
    logic              g_we;
    logic [31:0]       g_wdata;
    logic [1:0]        beat_nxt;
    logic [31:0]       rd_word;

    // Big-endian byte select: beat 0 is the most significant byte.
    function automatic logic [BYTE_W-1:0] wr_byte(input logic [31:0] w,
                                                  input logic [1:0]  b);
        case (b)
            2'd0:    wr_byte = w[31:24];
            2'd1:    wr_byte = w[23:16];
            2'd2:    wr_byte = w[15:8];
            default: wr_byte = w[7:0];
        endcase
    endfunction

    always_comb begin
        vld_if = if_req & ~mask_if;
        vld_d  = d_req & ~mask_d;
        // On contention the requester that did not win last time goes next.
        if (vld_if && vld_d) gnt_d = (last_gnt == REQ_IF);
        else                 gnt_d = vld_d;
        g_addr   = gnt_d ? d_addr  : if_addr;
        g_we     = gnt_d & d_we;
        g_wdata  = gnt_d ? d_wdata : 32'h0;
        beat_nxt = beat + 2'd1;
        // The last lane is still zero (cleared at grant) while beat 3 is on
        // the bus, so OR-ing in the live byte yields the complete word.
        rd_word  = asm_word | {24'h0, m_rdata};
    end

    byte_lane_assembler u_asm (
        .clk    (clk),
        .rst_n  (rst_n),
        .beat   (beat),
        .din    (m_rdata),
        .cap_en ((state == ST_XFER) && !lat_we),
        .clr    ((state == ST_IDLE) && (vld_if || vld_d)),
        .word   (asm_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            beat      <= 2'd0;
            lat_id    <= REQ_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            last_gnt  <= ~FIRST_GNT;
            mask_if   <= 1'b0;
            mask_d    <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
            m_addr    <= '0;
            m_we      <= 1'b0;
            m_wdata   <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The served requester is masked for exactly one idle cycle.
                    mask_if <= 1'b0;
                    mask_d  <= 1'b0;
                    if (vld_if || vld_d) begin
                        if (vld_if && vld_d) last_gnt <= gnt_d;
                        lat_id    <= gnt_d;
                        lat_we    <= g_we;
                        lat_addr  <= g_addr;
                        lat_wdata <= g_wdata;
                        // Present beat 0 directly from the grant edge.
                        m_addr    <= g_addr;
                        m_we      <= g_we;
                        m_wdata   <= wr_byte(g_wdata, 2'd0);
                        beat      <= 2'd0;
                        busy      <= 1'b1;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (beat == 2'(BEATS - 1)) begin
                        m_we  <= 1'b0;
                        beat  <= 2'd0;
                        state <= ST_DONE;
                        if (lat_id == REQ_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= lat_we ? 32'h0 : rd_word;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= rd_word;
                        end
                    end else begin
                        beat    <= beat_nxt;
                        // Natural wrap modulo 2^ADDR_W.
                        m_addr  <= lat_addr + ADDR_W'(beat_nxt);
                        m_wdata <= wr_byte(lat_wdata, beat_nxt);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (lat_id == REQ_D) mask_d  <= 1'b1;
                    else                 mask_if <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    m_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
